txt_console: RTL and testbench
==============================

Name: txt_console

Overview:
- Character-stream front end for the text-mode VGA path.
- Accepts bytes from the CPU/UART side over a valid/ready handshake and maintains a cursor.
- Writes ASCII codes into the 40x30 display memory that the text renderer reads. The memory is dual-port: this block owns one port, the renderer the other.
- Handles control codes, screen clear and hardware scroll, so the renderer always sees a coherent character grid.

Parameters:
- COLS, 40, characters per row.
- ROWS, 30, character rows.
- ADDR_W, 12, display memory address width; must satisfy 2^ADDR_W >= COLS*ROWS.
- BLANK, 8'h20, fill code used for clear, scroll and backspace.

Ports:
- clk  in  1  system clock.
- clr  in  1  reset.
- char_in  in  8  byte to display.
- char_valid  in  1  char_in valid.
- char_ready  out  1  block can accept a byte this cycle.
- mem_addr  out  ADDR_W  display memory address.
- mem_wdata  out  8  display memory write data.
- mem_en  out  1  display memory port enable.
- mem_we  out  1  display memory write enable.
- mem_rdata  in  8  display memory read data; valid the cycle after an enabled read.
- cursor_x  out  6  current column, 0..COLS-1.
- cursor_y  out  5  current row, 0..ROWS-1.
- busy  out  1  clear or scroll in progress.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-high on clr.
  - While clr=1, all outputs are 0 and the FSM is held in CLEAR with counter 0.
  - Reset mid-operation aborts any write or scroll immediately.
- States: CLEAR, IDLE, WRITE, SCROLL_RD, SCROLL_WR, SCROLL_CLR. All outputs are registered.
- Address: addr = y*COLS + x, computed as (y<<5)+(y<<3)+x for COLS=40, zero-extended to ADDR_W.
- Handshake:
  - char_ready=1 only in IDLE. A transfer occurs when char_valid & char_ready.
  - The source must hold char_in/char_valid while ready=0.
  - Bytes are never dropped.
- CLEAR:
  - Entered after reset release and on FF (0x0C).
  - Writes BLANK to addresses 0..COLS*ROWS-1 in ascending order, one per cycle (1200 cycles), with mem_en=mem_we=1.
  - Then cursor=(0,0) and the FSM goes to IDLE. busy=1 throughout.
- Printable byte (0x20..0x7E) accepted in cycle N:
  - Cycle N+1 (WRITE): mem_en=mem_we=1, mem_addr=addr(x,y), mem_wdata=char_in.
  - Cursor advances x+1. If x was COLS-1, x=0 and y+1.
  - If y would become ROWS, go to the scroll sequence; otherwise go to IDLE (ready high at N+2).
- CR (0x0D): x=0. Single cycle, back to IDLE, no memory access.
- LF (0x0A): x=0, y+1. At y=ROWS-1, scroll instead of incrementing.
- BS (0x08):
  - If x>0: x-1, and write BLANK at the new position via WRITE.
  - If x=0: no action. No reverse line wrap.
- All other codes (0x00..0x1F not listed, 0x7F..0xFF) are consumed and ignored.
- Scroll (busy=1):
  - For i=0..COLS*(ROWS-1)-1:
    - SCROLL_RD: mem_en=1, mem_we=0, addr=i+COLS.
    - SCROLL_WR: mem_en=mem_we=1, addr=i, wdata=mem_rdata.
  - Then SCROLL_CLR writes BLANK to the last row (COLS cycles).
  - Total 2*1160+40 = 2360 cycles. Cursor ends at (0,ROWS-1), then IDLE.
- mem_en=mem_we=0 in IDLE. The cursor never leaves range.

Optional Feature:
- Macro: TXT_CONSOLE_TAB_EN.
- Defined: TAB (0x09) sets x to the next multiple of 8, no memory write.
  - If the result is >= COLS, acts as LF (including scroll at the last row).
- Undefined: 0x09 is ignored like other unlisted control codes.

Test Plan:
- Release clr → busy=1 and ready=0 for 1200 cycles; mem writes 0x20 to addresses 0..1199; then ready=1, cursor=(0,0).
- After init, send 'A'(0x41), 'B' → writes addr 0=0x41, addr 1=0x42; cursor=(2,0); ready returns 2 cycles after each accept.
- Cursor (5,3), send 0x0D then 0x0A → cursor=(0,4), no mem_we; BS at (5,3) → write 0x20 at addr 124, cursor=(4,3).
- Preload row 1 with 'X', cursor (39,29), send 'Z' → write 'Z' at 1199, scroll 2360 cycles; row 0 holds 'X'; row 29 all 0x20; cursor=(0,29).
- Assert clr mid-scroll (cycle 500) → outputs 0 asynchronously; after release a full 1200-cycle clear runs and the cursor is (0,0).
- With TXT_CONSOLE_TAB_EN, cursor (3,0), send 0x09 → cursor (8,0). At (35,0), TAB → (0,1). Without the macro, the cursor is unchanged.

Source files
------------

// File: rtl/txt_console.sv
// txt_console: character-stream front end for the 40x30 text-mode display memory.
// Accepts bytes over valid/ready, tracks a cursor, writes glyph codes into one port
// of the dual-port display RAM, and handles CR, LF, BS, FF, screen clear and scroll.
//
// Ports:
//   clk, clr                 clock, asynchronous active-high reset
//   char_in, char_valid      byte stream from the CPU/UART side
//   char_ready               byte accepted when char_valid & char_ready
//   mem_addr/wdata/en/we     display memory port (owned by this block)
//   mem_rdata                read data, valid the cycle after an enabled read
//   cursor_x, cursor_y       current cursor position
//   busy                     clear or scroll in progress
//
// Build option: define TXT_CONSOLE_TAB_EN to make TAB (0x09) advance to the next
// multiple-of-8 column; otherwise TAB is ignored like other unlisted control codes.
module txt_console #(
  parameter int unsigned COLS   = 40,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned ADDR_W = 12,
  parameter logic [7:0]  BLANK  = 8'h20
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [7:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_en,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic [5:0]        cursor_x,
  output logic [4:0]        cursor_y,
  output logic              busy
);

  localparam int unsigned CELLS  = COLS * ROWS;
  localparam int unsigned MOVE_N = COLS * (ROWS - 1);
  localparam int unsigned CNT_W  = $clog2(CELLS + 1);

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    WRITE,
    SCROLL_RD,
    SCROLL_WR,
    SCROLL_CLR
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [5:0]        cx_n;
  logic [4:0]        cy_n;
  logic              pend, pend_n;
  logic              ready_n, en_n, we_n, busy_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        wdata_q, wdata_n;
  logic              do_lf, go_scroll;

`ifdef TXT_CONSOLE_TAB_EN
  logic [6:0] tab_x;
  assign tab_x = 7'({cursor_x[5:3], 3'b000}) + 7'd8;
`endif

  // Linear cell address y*COLS + x; shift-add form for the standard 40-column grid.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] x, input logic [4:0] y);
    if (COLS == 40)
      return (ADDR_W'(y) << 5) + (ADDR_W'(y) << 3) + ADDR_W'(x);
    else
      return ADDR_W'(y) * ADDR_W'(COLS) + ADDR_W'(x);
  endfunction

  // The RAM's read data is forwarded straight through during SCROLL_WR so the copy
  // keeps a two-cycle read/write rhythm; every other cycle drives the registered value.
  assign mem_wdata = (state == SCROLL_WR) ? mem_rdata : wdata_q;

  // Next state, next cursor and next registered outputs.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cx_n      = cursor_x;
    cy_n      = cursor_y;
    pend_n    = pend;
    ready_n   = 1'b0;
    en_n      = 1'b0;
    we_n      = 1'b0;
    busy_n    = 1'b0;
    addr_n    = '0;
    wdata_n   = '0;
    do_lf     = 1'b0;
    go_scroll = 1'b0;

    case (state)
      CLEAR: begin
        pend_n = 1'b0;
        if (cnt == CNT_W'(CELLS)) begin
          state_n = IDLE;
          ready_n = 1'b1;
          cnt_n   = '0;
          cx_n    = '0;
          cy_n    = '0;
        end else begin
          busy_n  = 1'b1;
          en_n    = 1'b1;
          we_n    = 1'b1;
          addr_n  = ADDR_W'(cnt);
          wdata_n = BLANK;
          cnt_n   = cnt + CNT_W'(1);
        end
      end

      IDLE: begin
        ready_n = 1'b1;
        if (char_valid && char_ready) begin
          if ((char_in >= 8'h20) && (char_in <= 8'h7E)) begin
            state_n = WRITE;
            ready_n = 1'b0;
            en_n    = 1'b1;
            we_n    = 1'b1;
            addr_n  = cell_addr(cursor_x, cursor_y);
            wdata_n = char_in;
            if (cursor_x == 6'(COLS - 1)) begin
              cx_n = '0;
              if (cursor_y == 5'(ROWS - 1)) pend_n = 1'b1;
              else                          cy_n   = cursor_y + 5'd1;
            end else begin
              cx_n = cursor_x + 6'd1;
            end
          end else begin
            case (char_in)
              8'h0D: cx_n = '0;
              8'h0A: do_lf = 1'b1;
              8'h08: begin
                if (cursor_x != 6'd0) begin
                  state_n = WRITE;
                  ready_n = 1'b0;
                  en_n    = 1'b1;
                  we_n    = 1'b1;
                  cx_n    = cursor_x - 6'd1;
                  addr_n  = cell_addr(cursor_x - 6'd1, cursor_y);
                  wdata_n = BLANK;
                end
              end
              8'h0C: begin
                // First clear write goes out immediately; counter continues from 1.
                state_n = CLEAR;
                ready_n = 1'b0;
                busy_n  = 1'b1;
                en_n    = 1'b1;
                we_n    = 1'b1;
                addr_n  = '0;
                wdata_n = BLANK;
                cnt_n   = CNT_W'(1);
              end
`ifdef TXT_CONSOLE_TAB_EN
              8'h09: begin
                if (tab_x >= 7'(COLS)) do_lf = 1'b1;
                else                   cx_n  = tab_x[5:0];
              end
`endif
              default: ;
            endcase
          end
        end
      end

      WRITE: begin
        if (pend) begin
          pend_n    = 1'b0;
          go_scroll = 1'b1;
        end else begin
          state_n = IDLE;
          ready_n = 1'b1;
        end
      end

      SCROLL_RD: begin
        state_n = SCROLL_WR;
        busy_n  = 1'b1;
        en_n    = 1'b1;
        we_n    = 1'b1;
        addr_n  = ADDR_W'(cnt);
      end

      SCROLL_WR: begin
        busy_n = 1'b1;
        en_n   = 1'b1;
        if (cnt == CNT_W'(MOVE_N - 1)) begin
          state_n = SCROLL_CLR;
          we_n    = 1'b1;
          cnt_n   = CNT_W'(MOVE_N);
          addr_n  = ADDR_W'(MOVE_N);
          wdata_n = BLANK;
        end else begin
          state_n = SCROLL_RD;
          cnt_n   = cnt + CNT_W'(1);
          addr_n  = ADDR_W'(cnt) + ADDR_W'(COLS + 1);
        end
      end

      SCROLL_CLR: begin
        if (cnt == CNT_W'(CELLS - 1)) begin
          state_n = IDLE;
          ready_n = 1'b1;
          cnt_n   = '0;
          cx_n    = '0;
          cy_n    = 5'(ROWS - 1);
        end else begin
          busy_n  = 1'b1;
          en_n    = 1'b1;
          we_n    = 1'b1;
          cnt_n   = cnt + CNT_W'(1);
          addr_n  = ADDR_W'(cnt) + ADDR_W'(1);
          wdata_n = BLANK;
        end
      end

      default: begin
        state_n = CLEAR;
        cnt_n   = '0;
      end
    endcase

    // Line feed: wrap to column 0, scroll instead of stepping past the last row.
    if (do_lf) begin
      cx_n = '0;
      if (cursor_y == 5'(ROWS - 1)) go_scroll = 1'b1;
      else                          cy_n      = cursor_y + 5'd1;
    end

    // Scroll starts with the read of cell COLS (row 1, column 0).
    if (go_scroll) begin
      state_n = SCROLL_RD;
      ready_n = 1'b0;
      busy_n  = 1'b1;
      en_n    = 1'b1;
      we_n    = 1'b0;
      cnt_n   = '0;
      addr_n  = ADDR_W'(COLS);
      wdata_n = '0;
    end
  end

  // State, cursor and output registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= CLEAR;
      cnt        <= '0;
      cursor_x   <= '0;
      cursor_y   <= '0;
      pend       <= 1'b0;
      char_ready <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      wdata_q    <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      cursor_x   <= cx_n;
      cursor_y   <= cy_n;
      pend       <= pend_n;
      char_ready <= ready_n;
      mem_en     <= en_n;
      mem_we     <= we_n;
      busy       <= busy_n;
      mem_addr   <= addr_n;
      wdata_q    <= wdata_n;
    end
  end

endmodule

// File: tb/tb_txt_console.sv
// tb_txt_console: self-checking bench for txt_console with a behavioural screen model.
// Provides the display RAM, drives bytes over the handshake and compares DUT
// memory writes, cursor and the whole screen image against the model.
module tb_txt_console;

  localparam int COLS  = 40;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic [5:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  int errors   = 0;
  int checks   = 0;
  int timeouts = 0;
  int wr_count = 0;

  logic [7:0] ram  [0:4095];
  logic [7:0] mscr [0:CELLS-1];
  int mx, my;

  txt_console dut (
    .clk(clk), .clr(clr), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous display RAM: read data appears the cycle after an enabled access.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
    if (mem_en && mem_we) wr_count <= wr_count + 1;
  end

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int i = 0; i < CELLS; i++) mscr[i] = 8'h20;
    mx = 0;
    my = 0;
  endfunction

  function automatic void model_newline();
    mx = 0;
    my = my + 1;
    if (my == ROWS) begin
      for (int i = 0; i < CELLS - COLS; i++) mscr[i] = mscr[i + COLS];
      for (int i = CELLS - COLS; i < CELLS; i++) mscr[i] = 8'h20;
      my = ROWS - 1;
    end
  endfunction

  function automatic void model_put(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      mscr[my * COLS + mx] = c;
      mx = mx + 1;
      if (mx == COLS) model_newline();
    end else if (c == 8'h0D) begin
      mx = 0;
    end else if (c == 8'h0A) begin
      model_newline();
    end else if (c == 8'h08) begin
      if (mx > 0) begin
        mx = mx - 1;
        mscr[my * COLS + mx] = 8'h20;
      end
    end else if (c == 8'h0C) begin
      model_clear();
`ifdef TXT_CONSOLE_TAB_EN
    end else if (c == 8'h09) begin
      mx = (mx / 8 + 1) * 8;
      if (mx >= COLS) model_newline();
`endif
    end
  endfunction

  function automatic int screen_diff();
    int n = 0;
    for (int i = 0; i < CELLS; i++) if (ram[i] !== mscr[i]) n++;
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; holds valid until accepted, returns at the following negedge.
  task automatic send(input logic [7:0] c);
    int t = 0;
    if (timeouts > 0) return;
    char_in = c;
    char_valid = 1'b1;
    while (!char_ready && t < 4000) begin @(negedge clk); t++; end
    if (!char_ready) begin
      timeouts++; errors++; checks++;
      $display("FAIL send_timeout: ready stayed 0 for %0d cycles, byte %h", t, c);
      char_valid = 1'b0;
      return;
    end
    @(negedge clk);
    char_valid = 1'b0;
    model_put(c);
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!char_ready && t < 4000) begin @(negedge clk); t++; end
  endtask

  // Observes a clear sequence until ready rises (bounded).
  task automatic watch_clear(output int n_wr, output int n_bad);
    int t = 0;
    n_wr = 0;
    n_bad = 0;
    @(negedge clk);
    while (!char_ready && t < 2000) begin
      if (mem_en && mem_we) begin
        if (mem_addr !== 12'(n_wr) || mem_wdata !== 8'h20 || busy !== 1'b1) n_bad++;
        n_wr++;
      end else if (mem_en) begin
        n_bad++;
      end
      t++;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [34:0] snap;
    int n_wr, n_bad;
    clr = 1'b1;
    char_valid = 1'b0;
    char_in = 8'h00;
    repeat (3) @(negedge clk);
    snap = {char_ready, busy, mem_en, mem_we, mem_addr, mem_wdata, cursor_x, cursor_y};
    checks++;
    if (snap !== 35'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", snap);
    end
    clr = 1'b0;
    model_clear();
    watch_clear(n_wr, n_bad);
    checks++;
    if (n_wr !== CELLS) begin errors++; $display("FAIL init_clear_count: got %0d want %0d", n_wr, CELLS); end
    checks++;
    if (n_bad !== 0) begin errors++; $display("FAIL init_clear_pattern: got %0d bad cycles want 0", n_bad); end
    checks++;
    if (char_ready !== 1'b1 || busy !== 1'b0 || cursor_x !== 6'd0 || cursor_y !== 5'd0) begin
      errors++; $display("FAIL init_done: got ready=%b busy=%b x=%0d y=%0d want 1 0 0 0",
                         char_ready, busy, cursor_x, cursor_y);
    end
  endtask

  task automatic test_print();
    logic [7:0] c;
    for (int i = 0; i < 2; i++) begin
      c = 8'h41 + 8'(i);
      wait_ready();
      char_in = c;
      char_valid = 1'b1;
      @(negedge clk);
      char_valid = 1'b0;
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'(i) || mem_wdata !== c || char_ready !== 1'b0) begin
        errors++; $display("FAIL print_write: got en=%b we=%b addr=%0d data=%h ready=%b want 1 1 %0d %h 0",
                           mem_en, mem_we, mem_addr, mem_wdata, char_ready, i, c);
      end
      @(negedge clk);
      checks++;
      if (char_ready !== 1'b1 || mem_en !== 1'b0) begin
        errors++; $display("FAIL print_ready: got ready=%b en=%b want 1 0", char_ready, mem_en);
      end
      model_put(c);
    end
    checks++;
    if (cursor_x !== 6'd2 || cursor_y !== 5'd0) begin
      errors++; $display("FAIL print_cursor: got (%0d,%0d) want (2,0)", cursor_x, cursor_y);
    end
  endtask

  task automatic test_ctrl();
    int n0;
    send(8'h0D);
    repeat (3) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
    wait_ready();
    checks++;
    if (cursor_x !== 6'd5 || cursor_y !== 5'd3) begin
      errors++; $display("FAIL ctrl_setup: got (%0d,%0d) want (5,3)", cursor_x, cursor_y);
    end
    char_in = 8'h08;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    model_put(8'h08);
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'd124 || mem_wdata !== 8'h20) begin
      errors++; $display("FAIL bs_write: got en=%b we=%b addr=%0d data=%h want 1 1 124 20",
                         mem_en, mem_we, mem_addr, mem_wdata);
    end
    wait_ready();
    checks++;
    if (cursor_x !== 6'd4 || cursor_y !== 5'd3) begin
      errors++; $display("FAIL bs_cursor: got (%0d,%0d) want (4,3)", cursor_x, cursor_y);
    end
    send(8'h71);
    wait_ready();
    n0 = wr_count;
    send(8'h0D);
    send(8'h0A);
    repeat (2) @(negedge clk);
    checks++;
    if (cursor_x !== 6'd0 || cursor_y !== 5'd4) begin
      errors++; $display("FAIL crlf_cursor: got (%0d,%0d) want (0,4)", cursor_x, cursor_y);
    end
    checks++;
    if (wr_count !== n0) begin
      errors++; $display("FAIL crlf_nowrite: got %0d writes want 0", wr_count - n0);
    end
    // BS at column 0 does nothing.
    send(8'h0D);
    n0 = wr_count;
    send(8'h08);
    repeat (2) @(negedge clk);
    checks++;
    if (cursor_x !== 6'd0 || cursor_y !== 5'd4 || wr_count !== n0) begin
      errors++; $display("FAIL bs_col0: got (%0d,%0d) writes=%0d want (0,4) 0", cursor_x, cursor_y, wr_count - n0);
    end
  endtask

  task automatic test_scroll();
    int n_busy, n_rd, n_wr, t, bad0, bad29;
    send(8'h0C);
    send(8'h0A);
    repeat (COLS) send(8'h58);
    repeat (27) send(8'h0A);
    for (int i = 0; i < COLS - 1; i++) send(8'($urandom_range(33, 126)));
    wait_ready();
    checks++;
    if (cursor_x !== 6'd39 || cursor_y !== 5'd29) begin
      errors++; $display("FAIL scroll_setup: got (%0d,%0d) want (39,29)", cursor_x, cursor_y);
    end
    char_in = 8'h5A;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    model_put(8'h5A);
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'd1199 || mem_wdata !== 8'h5A) begin
      errors++; $display("FAIL z_write: got en=%b we=%b addr=%0d data=%h want 1 1 1199 5a",
                         mem_en, mem_we, mem_addr, mem_wdata);
    end
    n_busy = 0; n_rd = 0; n_wr = 0; t = 0;
    @(negedge clk);
    while (!char_ready && t < 3000) begin
      if (busy) n_busy++;
      if (mem_en && !mem_we) n_rd++;
      if (mem_en && mem_we) n_wr++;
      t++;
      @(negedge clk);
    end
    checks++;
    if (n_busy !== 2360) begin errors++; $display("FAIL scroll_cycles: got %0d want 2360", n_busy); end
    checks++;
    if (n_rd !== 1160 || n_wr !== 1200) begin
      errors++; $display("FAIL scroll_access: got rd=%0d wr=%0d want 1160 1200", n_rd, n_wr);
    end
    bad0 = 0; bad29 = 0;
    for (int i = 0; i < COLS; i++) begin
      if (ram[i] !== 8'h58) bad0++;
      if (ram[CELLS - COLS + i] !== 8'h20) bad29++;
    end
    checks++;
    if (bad0 !== 0 || bad29 !== 0) begin
      errors++; $display("FAIL scroll_rows: got bad row0=%0d row29=%0d want 0 0", bad0, bad29);
    end
    checks++;
    if (cursor_x !== 6'd0 || cursor_y !== 5'd29) begin
      errors++; $display("FAIL scroll_cursor: got (%0d,%0d) want (0,29)", cursor_x, cursor_y);
    end
    checks++;
    if (screen_diff() !== 0) begin errors++; $display("FAIL scroll_screen: got %0d differing cells want 0", screen_diff()); end
  endtask

  task automatic test_reset_mid();
    logic [34:0] snap;
    int n_wr, n_bad;
    wait_ready();
    char_in = 8'h0A;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    repeat (499) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy: got %b want 1", busy); end
    #2 clr = 1'b1;
    #1 snap = {char_ready, busy, mem_en, mem_we, mem_addr, mem_wdata, cursor_x, cursor_y};
    checks++;
    if (snap !== 35'd0) begin errors++; $display("FAIL midreset_async: got %h want 0", snap); end
    repeat (2) @(negedge clk);
    clr = 1'b0;
    model_clear();
    watch_clear(n_wr, n_bad);
    checks++;
    if (n_wr !== CELLS || n_bad !== 0) begin
      errors++; $display("FAIL midreset_clear: got writes=%0d bad=%0d want %0d 0", n_wr, n_bad, CELLS);
    end
    checks++;
    if (cursor_x !== 6'd0 || cursor_y !== 5'd0 || char_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_cursor: got (%0d,%0d) ready=%b want (0,0) 1", cursor_x, cursor_y, char_ready);
    end
    checks++;
    if (screen_diff() !== 0) begin errors++; $display("FAIL midreset_screen: got %0d differing cells want 0", screen_diff()); end
  endtask

  task automatic test_tab();
    int ex1, ex2, ey2, guard;
`ifdef TXT_CONSOLE_TAB_EN
    ex1 = 8; ex2 = 0; ey2 = 1;
`else
    ex1 = 3; ex2 = 35; ey2 = 0;
`endif
    send(8'h0C);
    repeat (3) send(8'h74);
    send(8'h09);
    checks++;
    if (cursor_x !== 6'(ex1) || cursor_y !== 5'd0) begin
      errors++; $display("FAIL tab_step: got (%0d,%0d) want (%0d,0)", cursor_x, cursor_y, ex1);
    end
    guard = 0;
    while (mx != 35 && guard < 50) begin send(8'h75); guard++; end
    send(8'h09);
    checks++;
    if (cursor_x !== 6'(ex2) || cursor_y !== 5'(ey2)) begin
      errors++; $display("FAIL tab_wrap: got (%0d,%0d) want (%0d,%0d)", cursor_x, cursor_y, ex2, ey2);
    end
  endtask

  task automatic test_random();
    logic [7:0] c;
    int r, bad, guard;
    bad = 0;
    guard = 0;
    while (my < 22 && guard < 40) begin send(8'h0A); guard++; end
    for (int n = 0; n < 200 && timeouts == 0; n++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      c = 8'($urandom_range(32, 126));
      else if (r < 68) c = 8'h0A;
      else if (r < 76) c = 8'h0D;
      else if (r < 84) c = 8'h08;
      else if (r < 90) c = 8'h09;
      else if (r < 99) c = 8'($urandom_range(0, 255));
      else             c = 8'h0C;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(c);
      wait_ready();
      if (cursor_x !== 6'(mx) || cursor_y !== 5'(my)) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rand_cursor: got %0d cursor deviations want 0", bad); end
    checks++;
    if (screen_diff() !== 0) begin errors++; $display("FAIL rand_screen: got %0d differing cells want 0", screen_diff()); end
  endtask

  initial begin
    test_reset();
    test_print();
    test_ctrl();
    test_scroll();
    test_reset_mid();
    test_tab();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
